// File: rtl/unidad_pc_pkg.sv
// Shared constants and encodings for the program-counter stage.
// Imported by pc_target_mux and unidad_pc.
package unidad_pc_pkg;

    localparam int          WIDTH_DEF        = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } sel_e;

endpackage

// File: rtl/unidad_pc_pc_target_mux.sv
// Combinational next-PC target computation and priority select.
// Priority is jr > jump > branch_taken > sequential.
module pc_target_mux
    import unidad_pc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_base,
    input  logic [WIDTH-1:0] shifted_imm,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] next_pc,
    output logic [1:0]       sel,
    output logic             jr_misaligned
);

    sel_e sel_c;

    always_comb begin
        sel_c   = SEL_SEQ;
        next_pc = pc + WIDTH'(4);
        if (jr) begin
            sel_c   = SEL_JR;
            next_pc = {jr_addr[WIDTH-1:2], 2'b00};
        end else if (jump) begin
            sel_c   = SEL_J;
            next_pc = {branch_base[WIDTH-1:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            sel_c   = SEL_BR;
            next_pc = branch_base + shifted_imm;
        end
    end

    assign sel           = sel_c;
    assign jr_misaligned = jr && (jr_addr[1:0] != 2'b00);

endmodule

// File: rtl/unidad_pc.sv
// Program-counter stage: PC register, boot FSM, registered flush and misalign pulse.
//   state  | meaning
//   S_BOOT | one bubble after reset, pc held, fetch invalid
//   S_RUN  | normal fetch, pc follows selected target
module unidad_pc
    import unidad_pc_pkg::*;
#(
    parameter int               WIDTH        = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_base,
    input  logic [WIDTH-1:0] shifted_imm,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid,
    output logic             flush,
    output logic             addr_misaligned
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             flush_q, flush_d;
    logic             mis_q, mis_d;

    logic [WIDTH-1:0] next_pc;
    logic [1:0]       sel;
    logic             jr_misaligned;

    pc_target_mux #(.WIDTH(WIDTH)) u_mux (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_base   (branch_base),
        .shifted_imm   (shifted_imm),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .next_pc       (next_pc),
        .sel           (sel),
        .jr_misaligned (jr_misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_BOOT && !stall) begin
            state_d = S_RUN;
        end
    end

    // Datapath next values; stall freezes pc and flush but always clears the misalign pulse.
    always_comb begin
        pc_d    = pc_q;
        flush_d = flush_q;
        mis_d   = 1'b0;
        if (state_q == S_BOOT) begin
            flush_d = 1'b0;
        end else if (!stall) begin
            pc_d    = next_pc;
            flush_d = (sel != SEL_SEQ);
            mis_d   = jr_misaligned;
        end
    end

    always_comb begin
        pc              = pc_q;
        pc_plus4        = pc_q + WIDTH'(4);
        fetch_valid     = (state_q == S_RUN);
        flush           = flush_q;
        addr_misaligned = mis_q;
    end

endmodule

// File: tb/tb_unidad_pc.sv
// Self-checking bench for unidad_pc: directed scenarios plus randomized redirects
// against a behavioural next-PC model.
module tb_unidad_pc;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_base;
    logic [31:0] shifted_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic        addr_misaligned;

    int vectors;
    int miscompares;

    // behavioural model state
    logic [31:0] m_pc;
    logic        m_run;
    logic        m_flush;
    logic        m_mis;

    unidad_pc dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_base     (branch_base),
        .shifted_imm     (shifted_imm),
        .jump            (jump),
        .jump_index      (jump_index),
        .jr              (jr),
        .jr_addr         (jr_addr),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .flush           (flush),
        .addr_misaligned (addr_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; jump = 0; jr = 0;
        branch_base = 0; shifted_imm = 0; jump_index = 0; jr_addr = 0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_run = 0; m_flush = 0; m_mis = 0;
    endtask

    // One clock of the architectural rules, applied to the current inputs.
    task automatic model_step();
        if (!m_run) begin
            m_flush = 0;
            m_mis   = 0;
            if (!stall) m_run = 1;
        end else if (stall) begin
            m_mis = 0;
        end else begin
            m_mis   = 0;
            m_flush = 1;
            if (jr) begin
                m_pc  = jr_addr - (jr_addr % 4);
                m_mis = (jr_addr % 4) != 0;
            end else if (jump) begin
                m_pc = (branch_base & 32'hF000_0000) + 32'(jump_index) * 4;
            end else if (branch_taken) begin
                m_pc = branch_base + shifted_imm;
            end else begin
                m_pc    = m_pc + 4;
                m_flush = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        model_reset();
        @(posedge clk); #1;
        vectors++;
        if (pc !== 32'h0 || fetch_valid !== 0 || flush !== 0 || addr_misaligned !== 0) begin
            miscompares++;
            $display("FAIL reset: pc=%h fv=%b fl=%b mis=%b, want 0 0 0 0", pc, fetch_valid, flush, addr_misaligned);
        end
        reset = 0;
        #2;
        vectors++;
        if (pc !== 32'h0 || fetch_valid !== 0) begin
            miscompares++;
            $display("FAIL boot: pc=%h fv=%b, want 0 0", pc, fetch_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(); else begin model_step(); end
            vectors++;
            if (pc !== exp_seq[i] || fetch_valid !== 1 || pc_plus4 !== exp_seq[i] + 4) begin
                miscompares++;
                $display("FAIL seq[%0d]: pc=%h p4=%h fv=%b, want %h %h 1", i, pc, pc_plus4, fetch_valid, exp_seq[i], exp_seq[i] + 4);
            end
        end
    endtask

    task automatic test_branch();
        branch_base = 32'h0000_0010; shifted_imm = 32'hFFFF_FFF0; branch_taken = 1;
        tick();
        clear_inputs();
        vectors++;
        if (pc !== 32'h0 || flush !== 1) begin
            miscompares++;
            $display("FAIL branch: pc=%h flush=%b, want 00000000 1", pc, flush);
        end
        tick();
        vectors++;
        if (pc !== 32'h4 || flush !== 0) begin
            miscompares++;
            $display("FAIL branch_after: pc=%h flush=%b, want 00000004 0", pc, flush);
        end
    endtask

    task automatic test_jump_jr();
        branch_base = 32'h4000_0008; jump_index = 26'h0000123; jump = 1;
        tick();
        vectors++;
        if (pc !== 32'h4000_048C || flush !== 1) begin
            miscompares++;
            $display("FAIL jump: pc=%h flush=%b, want 4000048c 1", pc, flush);
        end
        jr = 1; branch_taken = 1; jr_addr = 32'h0000_2002;
        tick();
        clear_inputs();
        vectors++;
        if (pc !== 32'h0000_2000 || addr_misaligned !== 1 || flush !== 1) begin
            miscompares++;
            $display("FAIL jr_prio: pc=%h mis=%b flush=%b, want 00002000 1 1", pc, addr_misaligned, flush);
        end
        tick();
        vectors++;
        if (addr_misaligned !== 0 || flush !== 0 || pc !== 32'h0000_2004) begin
            miscompares++;
            $display("FAIL jr_pulse: pc=%h mis=%b flush=%b, want 00002004 0 0", pc, addr_misaligned, flush);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = pc;
        stall = 1; branch_taken = 1; branch_base = 32'h1000; shifted_imm = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (pc !== held || flush !== 0) begin
                miscompares++;
                $display("FAIL stall[%0d]: pc=%h flush=%b, want %h 0", i, pc, flush, held);
            end
        end
        clear_inputs();
        tick();
        vectors++;
        if (pc !== held + 4 || flush !== 0) begin
            miscompares++;
            $display("FAIL stall_release: pc=%h flush=%b, want %h 0", pc, flush, held + 4);
        end
    endtask

    task automatic test_wrap_async_reset();
        jr = 1; jr_addr = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        vectors++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || addr_misaligned !== 0) begin
            miscompares++;
            $display("FAIL wrap_setup: pc=%h p4=%h mis=%b, want fffffffc 00000000 0", pc, pc_plus4, addr_misaligned);
        end
        tick();
        vectors++;
        if (pc !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap: pc=%h, want 00000000", pc);
        end
        branch_taken = 1; branch_base = 32'h0000_0100; shifted_imm = 32'h0000_0020;
        tick();
        clear_inputs();
        #2;
        reset = 1;
        #1;
        model_reset();
        vectors++;
        if (pc !== 32'h0 || flush !== 0 || fetch_valid !== 0 || addr_misaligned !== 0) begin
            miscompares++;
            $display("FAIL async_reset: pc=%h fl=%b fv=%b mis=%b, want 0 0 0 0", pc, flush, fetch_valid, addr_misaligned);
        end
        #1;
        reset = 0;
        @(posedge clk); #1;
        model_step();
        vectors++;
        if (fetch_valid !== 1 || pc !== 32'h0) begin
            miscompares++;
            $display("FAIL after_reset: pc=%h fv=%b, want 00000000 1", pc, fetch_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            stall        = ($urandom_range(0, 3) == 0);
            jr           = ($urandom_range(0, 5) == 0);
            jump         = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            branch_base  = $urandom;
            shifted_imm  = {{14{1'b0}}, 16'($urandom), 2'b00} - 32'h0002_0000;
            jump_index   = 26'($urandom);
            jr_addr      = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            tick();
            vectors++;
            if (pc !== m_pc || pc_plus4 !== m_pc + 4 || fetch_valid !== m_run
                || flush !== m_flush || addr_misaligned !== m_mis) begin
                miscompares++;
                $display("FAIL random[%0d]: pc=%h p4=%h fv=%b fl=%b mis=%b, want %h %h %b %b %b",
                         i, pc, pc_plus4, fetch_valid, flush, addr_misaligned,
                         m_pc, m_pc + 4, m_run, m_flush, m_mis);
            end
        end
        clear_inputs();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clear_inputs();
        model_reset();
        reset = 1;
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_jump_jr();
        test_stall();
        test_wrap_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
